// File: rtl/pc_sequencer_if.sv
// Bundle of the command, fetch-port, block-move and PC-adder signals around pc_sequencer.
// The slave modport is the sequencer; the master modport is decode/memory/adder surroundings.
interface pc_sequencer_if #(
  parameter int ABW = 24
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic [ABW-1:0] cmd_data;
  logic           cmd_take;
  logic           done;
  logic           aborted;
  logic           fetch_req;
  logic [ABW-1:0] fetch_addr;
  logic           fetch_ack;
  logic [7:0]     fetch_data;
  logic [7:0]     rsp_data;
  logic           mv_step;
  logic           irq_req;
  logic           mv_busy;
  logic [1:0]     add_op;
  logic [ABW-1:0] add_pc;
  logic [ABW-1:0] add_disp;
  logic [ABW-1:0] add_o;
  logic [ABW-1:0] pc;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_take,
    input  fetch_ack, fetch_data, mv_step, irq_req, add_o,
    output cmd_ready, done, aborted, fetch_req, fetch_addr, rsp_data,
    output mv_busy, add_op, add_pc, add_disp, pc
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_take,
    output fetch_ack, fetch_data, mv_step, irq_req, add_o,
    input  cmd_ready, done, aborted, fetch_req, fetch_addr, rsp_data,
    input  mv_busy, add_op, add_pc, add_disp, pc
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, steers the external PC adder, runs opcode/operand
// fetches, relative branches, jumps and the MVN/MVP block-move loop with interrupt rewind.
module pc_sequencer #(
  parameter int             ABW      = 24,
  parameter logic [ABW-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_MOVE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_FETCH = 3'd0;
  localparam logic [2:0] OP_BR8   = 3'd1;
  localparam logic [2:0] OP_BR16  = 3'd2;
  localparam logic [2:0] OP_JMP   = 3'd3;
  localparam logic [2:0] OP_MOVE  = 3'd4;

  localparam logic [1:0] ADD_HOLD = 2'd0;
  localparam logic [1:0] ADD_INC  = 2'd1;
  localparam logic [1:0] ADD_DISP = 2'd2;
  localparam logic [1:0] ADD_REW3 = 2'd3;

  state_t         state_q, state_d;
  logic [ABW-1:0] pc_q, pc_d;
  logic [15:0]    mv_cnt_q, mv_cnt_d;
  logic [7:0]     rsp_data_q, rsp_data_d;
  logic           done_q, done_d;
  logic           aborted_q, aborted_d;
  logic [1:0]     add_op;
  logic [ABW-1:0] add_disp;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mv_cnt_d   = mv_cnt_q;
    rsp_data_d = rsp_data_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    add_op     = ADD_HOLD;
    add_disp   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_FETCH: state_d = ST_FETCH;
            OP_BR8: begin
              done_d = 1'b1;
              if (bus.cmd_take) begin
                add_op   = ADD_DISP;
                add_disp = {{(ABW-8){bus.cmd_data[7]}}, bus.cmd_data[7:0]};
                pc_d     = bus.add_o;
              end
            end
            OP_BR16: begin
              done_d = 1'b1;
              if (bus.cmd_take) begin
                add_op   = ADD_DISP;
                add_disp = {{(ABW-16){bus.cmd_data[15]}}, bus.cmd_data[15:0]};
                pc_d     = bus.add_o;
              end
            end
            OP_JMP: begin
              done_d = 1'b1;
              pc_d   = bus.cmd_data;
            end
            OP_MOVE: begin
              state_d  = ST_MOVE;
              mv_cnt_d = bus.cmd_data[15:0];
            end
            default: done_d = 1'b1;
          endcase
        end
      end

      ST_FETCH: begin
        if (bus.fetch_ack) begin
          add_op     = ADD_INC;
          pc_d       = bus.add_o;
          rsp_data_d = bus.fetch_data;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_MOVE: begin
        // A step always beats a simultaneous interrupt; the interrupt is looked at again next cycle.
        if (bus.mv_step) begin
          if (mv_cnt_q == 16'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            mv_cnt_d = mv_cnt_q - 16'd1;
          end
        end else if (bus.irq_req) begin
          add_op    = ADD_REW3;
          pc_d      = bus.add_o;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      mv_cnt_q   <= '0;
      rsp_data_q <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mv_cnt_q   <= mv_cnt_d;
      rsp_data_q <= rsp_data_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.fetch_req  = (state_q == ST_FETCH);
  assign bus.mv_busy    = (state_q == ST_MOVE);
  assign bus.fetch_addr = pc_q;
  assign bus.add_pc     = pc_q;
  assign bus.pc         = pc_q;
  assign bus.add_op     = add_op;
  assign bus.add_disp   = add_disp;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table of single-cycle commands issued back-to-back,
// plus hand sequences for fetch, block move, interrupt rewind and mid-operation reset.
module tb_pc_sequencer;
  localparam int ABW = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests  = 0;
  int   failed = 0;

  pc_sequencer_if #(.ABW(ABW)) bus ();

  pc_sequencer #(.ABW(ABW), .RESET_PC(24'h000000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // PC adder sitting downstream of the sequencer
  assign bus.add_o = (bus.add_op == 2'd1) ? bus.add_pc + 24'd1 :
                     (bus.add_op == 2'd2) ? bus.add_pc + bus.add_disp :
                     (bus.add_op == 2'd3) ? bus.add_pc - 24'd3 : bus.add_pc;

  typedef struct {
    logic [2:0]  op;
    logic [23:0] data;
    logic        take;
    logic [23:0] exp_pc;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [23:0] data, input logic take);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_take  = take;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("cmd_done", 32'(bus.done), 32'd1);
  endtask

  task automatic do_fetch(input int waits, input logic [7:0] d, input logic [23:0] exp_pc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("fetch_req_first", 32'(bus.fetch_req), 32'd1);
    check("fetch_busy_ready", 32'(bus.cmd_ready), 32'd0);
    for (int w = 0; w < waits; w++) begin
      @(posedge clk);
      @(negedge clk);
      check("fetch_req_wait", 32'(bus.fetch_req), 32'd1);
      check("fetch_no_early_done", 32'(bus.done), 32'd0);
    end
    bus.fetch_ack  = 1'b1;
    bus.fetch_data = d;
    @(posedge clk);
    @(negedge clk);
    bus.fetch_ack = 1'b0;
    check("fetch_done", 32'(bus.done), 32'd1);
    check("fetch_pc", 32'(bus.pc), 32'(exp_pc));
    check("fetch_rsp", 32'(bus.rsp_data), 32'(d));
    check("fetch_req_drop", 32'(bus.fetch_req), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("fetch_done_single", 32'(bus.done), 32'd0);
    $display("[TB] FETCH d=0x%02h pc=0x%06h", d, bus.pc);
  endtask

  task automatic start_move(input logic [15:0] count);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd4;
    bus.cmd_data  = {8'h00, count};
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("move_busy", 32'(bus.mv_busy), 32'd1);
    check("move_not_ready", 32'(bus.cmd_ready), 32'd0);
  endtask

  task automatic step_cycle(input logic s, input logic irq);
    bus.mv_step = s;
    bus.irq_req = irq;
    @(posedge clk);
    @(negedge clk);
    bus.mv_step = 1'b0;
    bus.irq_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd3, 24'h001000, 1'b0, 24'h001000};
    vecs[1] = '{3'd1, 24'h0000F0, 1'b1, 24'h000FF0};
    vecs[2] = '{3'd1, 24'h0000F0, 1'b0, 24'h000FF0};
    vecs[3] = '{3'd3, 24'h001000, 1'b0, 24'h001000};
    vecs[4] = '{3'd2, 24'h008000, 1'b1, 24'hFF9000};
    vecs[5] = '{3'd3, 24'h123456, 1'b0, 24'h123456};
    vecs[6] = '{3'd5, 24'hABCDEF, 1'b1, 24'h123456};
    vecs[7] = '{3'd1, 24'hFFFF10, 1'b1, 24'h123466};
    vecs[8] = '{3'd2, 24'hAB7FFF, 1'b1, 24'h12B465};
    vecs[9] = '{3'd3, 24'hFFFFFF, 1'b0, 24'hFFFFFF};

    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 3'd0;
    bus.cmd_data   = '0;
    bus.cmd_take   = 1'b0;
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = 8'h00;
    bus.mv_step    = 1'b0;
    bus.irq_req    = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_aborted", 32'(bus.aborted), 32'd0);
    check("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
    check("rst_mv_busy", 32'(bus.mv_busy), 32'd0);
    check("rst_add_op", 32'(bus.add_op), 32'd0);
    check("rst_pc", 32'(bus.pc), 32'h000000);
    check("rst_rsp", 32'(bus.rsp_data), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // First fetch: ack arrives in the second FETCH cycle
    do_fetch(1, 8'hA9, 24'h000001);

    // irq outside MOVE has no effect
    bus.irq_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.irq_req = 1'b0;
    check("irq_idle_pc", 32'(bus.pc), 32'h000001);
    check("irq_idle_done", 32'(bus.done), 32'd0);
    check("idle_add_op", 32'(bus.add_op), 32'd0);

    // Back-to-back single-cycle commands, cmd_valid held throughout
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = vecs[i].op;
      bus.cmd_data  = vecs[i].data;
      bus.cmd_take  = vecs[i].take;
      @(posedge clk);
      @(negedge clk);
      check("vec_done", 32'(bus.done), 32'd1);
      check("vec_pc", 32'(bus.pc), 32'(vecs[i].exp_pc));
      check("vec_ready", 32'(bus.cmd_ready), 32'd1);
      $display("[TB] vec %0d op=%0d data=0x%06h take=%0d pc=0x%06h", i, vecs[i].op,
               vecs[i].data, vecs[i].take, bus.pc);
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_take  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("vec_done_stop", 32'(bus.done), 32'd0);
    check("rsp_held", 32'(bus.rsp_data), 32'hA9);

    // Fetch wrap at top of address space, ack in first FETCH cycle
    do_fetch(0, 8'h5C, 24'h000000);

    // MOVE interrupted before any step: rewind wraps below zero
    do_cmd(3'd3, 24'h000001, 1'b0);
    start_move(16'd4);
    step_cycle(1'b0, 1'b1);
    check("irq0_done", 32'(bus.done), 32'd1);
    check("irq0_aborted", 32'(bus.aborted), 32'd1);
    check("irq0_pc", 32'(bus.pc), 32'hFFFFFE);
    check("irq0_busy", 32'(bus.mv_busy), 32'd0);
    $display("[TB] MOVE irq-before-step pc=0x%06h", bus.pc);

    // MOVE count 2: three steps with gaps
    do_cmd(3'd3, 24'h004444, 1'b0);
    start_move(16'd2);
    step_cycle(1'b1, 1'b0);
    step_cycle(1'b0, 1'b0);
    step_cycle(1'b1, 1'b0);
    check("mv2_busy", 32'(bus.mv_busy), 32'd1);
    check("mv2_no_done", 32'(bus.done), 32'd0);
    step_cycle(1'b0, 1'b0);
    step_cycle(1'b1, 1'b0);
    check("mv2_done", 32'(bus.done), 32'd1);
    check("mv2_aborted", 32'(bus.aborted), 32'd0);
    check("mv2_pc", 32'(bus.pc), 32'h004444);
    @(posedge clk);
    @(negedge clk);
    check("mv2_done_single", 32'(bus.done), 32'd0);
    $display("[TB] MOVE count2 pc=0x%06h", bus.pc);

    // Final step coincides with irq: completes without abort
    start_move(16'd1);
    step_cycle(1'b1, 1'b0);
    step_cycle(1'b1, 1'b1);
    check("mvfin_done", 32'(bus.done), 32'd1);
    check("mvfin_aborted", 32'(bus.aborted), 32'd0);
    check("mvfin_pc", 32'(bus.pc), 32'h004444);
    $display("[TB] MOVE final-step+irq pc=0x%06h", bus.pc);

    // Non-final step with irq: step wins, irq still pending aborts next cycle
    start_move(16'd2);
    step_cycle(1'b1, 1'b1);
    check("mvmid_busy", 32'(bus.mv_busy), 32'd1);
    check("mvmid_no_done", 32'(bus.done), 32'd0);
    check("mvmid_pc", 32'(bus.pc), 32'h004444);
    step_cycle(1'b0, 1'b1);
    check("mvmid_abort", 32'(bus.aborted), 32'd1);
    check("mvmid_pc_rew", 32'(bus.pc), 32'h004441);
    $display("[TB] MOVE step-then-irq pc=0x%06h", bus.pc);

    // MOVE count 5, irq after two steps
    do_cmd(3'd3, 24'h002003, 1'b0);
    start_move(16'd5);
    step_cycle(1'b1, 1'b0);
    step_cycle(1'b1, 1'b0);
    step_cycle(1'b0, 1'b1);
    check("mv5_pc", 32'(bus.pc), 32'h002000);
    check("mv5_done", 32'(bus.done), 32'd1);
    check("mv5_aborted", 32'(bus.aborted), 32'd1);
    check("mv5_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("mv5_aborted_single", 32'(bus.aborted), 32'd0);
    $display("[TB] MOVE count5 irq pc=0x%06h", bus.pc);

    // Reset in the middle of a fetch
    do_cmd(3'd3, 24'h000500, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("rstf_req_before", 32'(bus.fetch_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstf_req", 32'(bus.fetch_req), 32'd0);
    check("rstf_pc", 32'(bus.pc), 32'h000000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("rstf_no_done", 32'(bus.done), 32'd0);
      check("rstf_idle", 32'(bus.fetch_req), 32'd0);
    end
    $display("[TB] reset mid-FETCH pc=0x%06h", bus.pc);

    // Reset in the middle of a move
    do_cmd(3'd3, 24'h000700, 1'b0);
    start_move(16'd3);
    step_cycle(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rstm_busy", 32'(bus.mv_busy), 32'd0);
    check("rstm_pc", 32'(bus.pc), 32'h000000);
    @(negedge clk);
    rst_n = 1'b1;
    step_cycle(1'b1, 1'b0);
    check("rstm_no_done", 32'(bus.done), 32'd0);
    step_cycle(1'b0, 1'b1);
    check("rstm_no_abort", 32'(bus.aborted), 32'd0);
    check("rstm_pc_after", 32'(bus.pc), 32'h000000);
    $display("[TB] reset mid-MOVE pc=0x%06h", bus.pc);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the bc6502 core: owns the PC register and drives the PC adder (increment, displacement, rewind-by-3) through its op/disp/pc inputs, consuming the adder's result each time it updates. It sits directly upstream of the PC adder and between the decode/control logic and the instruction-fetch memory port. It serves opcode and operand fetches, 8/16-bit relative branches, absolute jumps, and the MVN/MVP block-move loop with interrupt rewind.

## Interface
- ABW, 24, address/PC width
- RESET_PC, 24'h000000, PC value loaded on reset
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (IDLE only)
- cmd_op  in  3  0 FETCH, 1 BR8, 2 BR16, 3 JMP, 4 MOVE, 5-7 reserved (NOP)
- cmd_data  in  ABW  BR8: [7:0] disp; BR16: [15:0] disp; JMP: target; MOVE: [15:0] count
- cmd_take  in  1  branch taken (BR8/BR16 only)
- done  out  1  one-cycle pulse: command complete
- aborted  out  1  valid with done: MOVE terminated by interrupt
- fetch_req  out  1  memory read request
- fetch_addr  out  ABW  equals pc
- fetch_ack  in  1  read data valid this cycle
- fetch_data  in  8  read byte
- rsp_data  out  8  last fetched byte, held until next FETCH completes
- mv_step  in  1  datapath moved one byte this cycle
- irq_req  in  1  interrupt pending
- mv_busy  out  1  high in MOVE state
- add_op  out  2  to PC adder: 0 pc-0, 1 pc+1, 2 pc+disp, 3 pc-3
- add_pc  out  ABW  to PC adder; equals pc
- add_disp  out  ABW  to PC adder; sign-extended displacement
- add_o  in  ABW  PC adder result (combinational)
- pc  out  ABW  current program counter

## Operation
- States: IDLE, FETCH, MOVE. Reset: IDLE, pc=RESET_PC, mv_cnt=0, rsp_data=0; outputs cmd_ready=1, done=0, aborted=0, fetch_req=0, mv_busy=0, add_op=0.
- Accept = cmd_valid & cmd_ready at a rising edge. cmd_ready=0 in FETCH/MOVE; cmd_valid is held by the source until accepted.
- add_op defaults to 0 and add_disp to 0 whenever pc is not being updated; pc is loaded only from add_o, or from cmd_data for JMP.
- FETCH: accept -> FETCH; fetch_req=1, fetch_addr=pc. On fetch_ack, add_op=1; at that edge pc<=add_o and rsp_data<=fetch_data; -> IDLE, done=1 next cycle.
- BR8: at the accept edge, if cmd_take then add_op=2, add_disp=sext(cmd_data[7:0]), pc<=add_o; else pc unchanged. Stays IDLE; done next cycle.
- BR16: as BR8 with add_disp=sext(cmd_data[15:0]).
- JMP: pc<=cmd_data at the accept edge; done next cycle.
- Reserved ops: no state change, done next cycle.
- MOVE: accept -> MOVE, mv_cnt<=cmd_data[15:0], mv_busy=1.
  - On mv_step: if mv_cnt==0, then done and -> IDLE (pc unchanged). Otherwise mv_cnt<=mv_cnt-1.
  - irq_req with mv_step low: add_op=3, pc<=add_o (pc-3, restarts the instruction after the interrupt), done=1 and aborted=1 next cycle, -> IDLE.
  - mv_step and irq_req in the same cycle: step wins. irq_req is re-evaluated the next cycle only if still in MOVE; a final step completes the move without abort.
- irq_req is ignored outside MOVE.
- Arithmetic is modulo 2^ABW: 0xFFFFFF+1=0x000000; 0x000001-3=0xFFFFFE; a negative displacement wraps likewise.

## Timing
- done/aborted are registered and high for exactly one cycle, the cycle after the completing edge. cmd_ready is also high in that cycle, so back-to-back commands are accepted.
- FETCH latency: done one cycle after the fetch_ack edge. Minimum 2 cycles from accept, with fetch_ack in the first FETCH cycle.
- BR8/BR16/JMP: pc valid one cycle after the accept edge; done in that same cycle.
- MOVE: count N needs N+1 mv_step pulses.
- rst_n low at any time: immediate return to reset values. An in-flight fetch is dropped (fetch_req falls asynchronously), no done is issued, and a partial MOVE is discarded.

## Test plan
- Reset, then FETCH at pc=0x000000 with fetch_ack+fetch_data=0xA9 two cycles later -> fetch_req high 2 cycles, pc=0x000001, rsp_data=0xA9, single done pulse.
- pc=0x001000: BR8 disp 0xF0 taken -> pc=0x000FF0; BR8 not taken -> pc stays; BR16 0x8000 from 0x001000 -> pc=0xFF9000; JMP 0x123456 -> pc=0x123456. Each issued back-to-back, one done each.
- pc=0xFFFFFF FETCH -> pc=0x000000; pc=0x000001, MOVE with irq before any step -> pc=0xFFFFFE, aborted=1.
- MOVE count 2, three mv_step pulses with gaps -> done after the third, pc unchanged; mv_step and irq_req together on the last step -> done, aborted=0, pc unchanged.
- MOVE count 5 at pc=0x002003, irq_req after two steps -> pc=0x002000, done+aborted one cycle later, cmd_ready=1.
- rst_n asserted mid-FETCH and mid-MOVE -> immediate pc=RESET_PC, fetch_req=0, mv_busy=0, no done pulse after release.
